// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoder controls and operands in, EX fields and stall enables out.
// The master side drives the ID stage fields; the slave side is the pipeline register.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_RegDst;
  logic              id_ALUSrc;
  logic              id_MemtoReg;
  logic              id_RegWrite;
  logic              id_MemRead;
  logic              id_MemWrite;
  logic              id_Branch;
  logic [1:0]        id_ALUOp;
  logic [DATA_W-1:0] id_pc_plus4;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              flush;

  logic              ex_RegDst;
  logic              ex_ALUSrc;
  logic              ex_MemtoReg;
  logic              ex_RegWrite;
  logic              ex_MemRead;
  logic              ex_MemWrite;
  logic              ex_Branch;
  logic [1:0]        ex_ALUOp;
  logic [DATA_W-1:0] ex_pc_plus4;
  logic [DATA_W-1:0] ex_rd1;
  logic [DATA_W-1:0] ex_rd2;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_valid;
  logic              pc_write;
  logic              if_id_write;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
    output id_MemRead, id_MemWrite, id_Branch, id_ALUOp,
    output id_pc_plus4, id_rd1, id_rd2, id_imm,
    output id_rs, id_rt, id_rd, flush,
    input  ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
    input  ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUOp,
    input  ex_pc_plus4, ex_rd1, ex_rd2, ex_imm,
    input  ex_rs, ex_rt, ex_rd, ex_valid,
    input  pc_write, if_id_write, bubble_count
  );

  modport slave (
    input  id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
    input  id_MemRead, id_MemWrite, id_Branch, id_ALUOp,
    input  id_pc_plus4, id_rd1, id_rd2, id_imm,
    input  id_rs, id_rt, id_rd, flush,
    output ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
    output ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUOp,
    output ex_pc_plus4, ex_rd1, ex_rd2, ex_imm,
    output ex_rs, ex_rt, ex_rd, ex_valid,
    output pc_write, if_id_write, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and
// a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic       regDst;
    logic       aluSrc;
    logic       memtoReg;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic [1:0] aluOp;
  } ctl_t;

  typedef struct packed {
    logic [DATA_W-1:0] pcPlus4;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } opnd_t;

  localparam logic [REG_AW-1:0] RegZero = '0;
  localparam logic [CNT_W-1:0]  CntMax  = '1;

  ctl_t             ctlD;
  ctl_t             ctlQ;
  opnd_t            opndD;
  opnd_t            opndQ;
  logic             validQ;
  logic [CNT_W-1:0] bubbleQ;
  logic             useRt;
  logic             hazard;
  logic             bubble;

  assign ctlD = {
    bus.id_RegDst, bus.id_ALUSrc, bus.id_MemtoReg,
    bus.id_RegWrite, bus.id_MemRead, bus.id_MemWrite,
    bus.id_Branch, bus.id_ALUOp
  };

  assign opndD = {
    bus.id_pc_plus4, bus.id_rd1, bus.id_rd2, bus.id_imm,
    bus.id_rs, bus.id_rt, bus.id_rd
  };

  // LW does not read rt, so only R-type, SW and BEQ compare it
  assign useRt = bus.id_RegDst | bus.id_MemWrite | bus.id_Branch;

  assign hazard = ctlQ.memRead & validQ
                & (opndQ.rt != RegZero)
                & ((opndQ.rt == bus.id_rs)
                 | (useRt & (opndQ.rt == bus.id_rt)));

  assign bubble = bus.flush | hazard;

  // A flushed instruction is dropped anyway, so it never holds the front end
  assign bus.pc_write    = ~(hazard & ~bus.flush);
  assign bus.if_id_write = ~(hazard & ~bus.flush);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctlQ    <= '0;
      opndQ   <= '0;
      validQ  <= 1'b0;
      bubbleQ <= '0;
    end else begin
      opndQ  <= opndD;
      ctlQ   <= bubble ? ctl_t'('0) : ctlD;
      validQ <= ~bubble;
      if (bubble && (bubbleQ != CntMax))
        bubbleQ <= bubbleQ + CNT_W'(1);
    end
  end

  assign bus.ex_RegDst    = ctlQ.regDst;
  assign bus.ex_ALUSrc    = ctlQ.aluSrc;
  assign bus.ex_MemtoReg  = ctlQ.memtoReg;
  assign bus.ex_RegWrite  = ctlQ.regWrite;
  assign bus.ex_MemRead   = ctlQ.memRead;
  assign bus.ex_MemWrite  = ctlQ.memWrite;
  assign bus.ex_Branch    = ctlQ.branch;
  assign bus.ex_ALUOp     = ctlQ.aluOp;
  assign bus.ex_pc_plus4  = opndQ.pcPlus4;
  assign bus.ex_rd1       = opndQ.rd1;
  assign bus.ex_rd2       = opndQ.rd2;
  assign bus.ex_imm       = opndQ.imm;
  assign bus.ex_rs        = opndQ.rs;
  assign bus.ex_rt        = opndQ.rt;
  assign bus.ex_rd        = opndQ.rd;
  assign bus.ex_valid     = validQ;
  assign bus.bubble_count = bubbleQ;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX boundary of the 5-stage pipelined MIPS core.
- Sits directly downstream of the opcode control decoder: latches its control bundle plus decoded register operands into the EX stage.
- Detects load-use hazards and inserts bubbles. Squashes the ID instruction on a taken-branch flush from MEM.
- Drives the PC and IF/ID write enables and keeps a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 32, datapath width of PC, register and immediate fields
- REG_AW, 5, register specifier width
- CNT_W, 16, width of the bubble counter (saturating)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch  in  1 each  control bits from decoder
- id_ALUOp  in  2  ALU op class from decoder
- id_pc_plus4  in  DATA_W  PC+4 of ID instruction
- id_rd1, id_rd2  in  DATA_W  register file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_AW  register specifiers
- flush  in  1  taken branch resolved in MEM; squash ID instruction
- ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch  out  1 each  registered control
- ex_ALUOp  out  2  registered ALUOp
- ex_pc_plus4, ex_rd1, ex_rd2, ex_imm  out  DATA_W  registered data
- ex_rs, ex_rt, ex_rd  out  REG_AW  registered specifiers
- ex_valid  out  1  EX holds a real (non-bubble) instruction
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register write enable
- bubble_count  out  CNT_W  number of bubbles inserted since reset

Behaviour:
- Reset (async, active-high): all ex_* outputs 0, ex_valid 0, bubble_count 0. While reset is high, pc_write=1 and if_id_write=1.
- use_rt = id_RegDst | id_MemWrite | id_Branch (R-type, SW, BEQ read rt; LW does not).
- Load-use hazard (combinational from registered state and ID inputs):
  - hazard = ex_MemRead & ex_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (use_rt & (ex_rt == id_rt))).
- Stall outputs (combinational):
  - pc_write = if_id_write = ~(hazard & ~flush).
  - flush overrides stall because the stalled instruction is squashed anyway.
- Each rising clk edge, priority order:
  1. flush=1: all control outputs <= 0, ex_ALUOp <= 0, ex_valid <= 0. Data and specifier fields still load from inputs. bubble_count +1.
  2. hazard=1: same bubble insertion as flush (control 0, ex_valid 0, data loaded), bubble_count +1.
  3. Otherwise: every ex_* field <= its id_* counterpart, ex_valid <= 1.
- Single-cycle latency ID→EX. A load-use stall lasts exactly one cycle: after the bubble, ex_MemRead=0, so hazard clears.
- bubble_count saturates at 2^CNT_W-1. It never wraps.
- Register $0: ex_rt==0 never raises a hazard, even when ex_MemRead=1.
- Decoder default (unknown opcode, all controls 0) passes through with ex_valid=1. No special handling.
- Reset asserted mid-stall: outputs clear immediately (async). Hazard drops because ex_valid=0.

Test Plan:
- Reset then R-type passthrough: reset high 2 cycles, release; drive id_RegDst=1, id_RegWrite=1, ALUOp=10, rs=1, rt=2, rd=3, rd1=0x11, rd2=0x22 → next edge ex_RegDst=1, ex_RegWrite=1, ex_ALUOp=10, ex_rd=3, ex_rd1=0x11, ex_rd2=0x22, ex_valid=1, pc_write=1.
- Load-use stall: LW rt=5 in EX, then ID add with rs=5 → pc_write=0 and if_id_write=0 for one cycle. Next edge: EX controls all 0, ex_valid=0, bubble_count=1. Following cycle pc_write=1 and the add latches.
- No false hazard: LW rt=5 in EX, ID LW with rt=5, rs=7 (use_rt=0) → no stall. Separately, LW rt=0 in EX with ID rs=0 → no stall.
- Flush beats hazard: hazard condition plus flush=1 in the same cycle → pc_write=1, if_id_write=1. Next edge ex_valid=0 and controls 0, bubble_count +1.
- Saturation: with CNT_W=2, insert 5 bubbles → bubble_count sequence 1,2,3,3,3.
- Async reset mid-stall: assert reset between edges during hazard → all ex_* outputs 0 and bubble_count 0 without a clock edge; pc_write=1.
